// File: rtl/video_stream_monitor.sv
// video_stream_monitor: zero-latency AXI4-Stream video pass-through with component
// width reduction and a beat-based frame-geometry monitor with sticky errors.
module video_stream_monitor #(
  parameter int NUM_COMP   = 3,
  parameter int IN_COMP_W  = 10,
  parameter int OUT_COMP_W = 8,
  parameter int ROUND      = 0,
  parameter int EXP_WIDTH  = 1280,
  parameter int EXP_HEIGHT = 720,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           clr,
  input  logic [NUM_COMP*IN_COMP_W-1:0]  s_axis_video_tdata,
  input  logic                           s_axis_video_tvalid,
  input  logic                           s_axis_video_tuser,
  input  logic                           s_axis_video_tlast,
  output logic                           s_axis_video_tready,
  output logic [NUM_COMP*OUT_COMP_W-1:0] m_axis_video_tdata,
  output logic                           m_axis_video_tvalid,
  output logic                           m_axis_video_tuser,
  output logic                           m_axis_video_tlast,
  input  logic                           m_axis_video_tready,
  output logic                           in_frame,
  output logic [31:0]                    frame_count,
  output logic [CNT_W-1:0]               last_width,
  output logic [CNT_W-1:0]               last_height,
  output logic [31:0]                    frame_period,
  output logic [31:0]                    stall_count,
  output logic                           err_width,
  output logic                           err_height,
  output logic                           err_sof,
  output logic                           err_orphan
);
  typedef enum logic {WAIT_SOF, IN_FRAME} state_t;
  state_t state_q;
  logic have_sof_q;
  logic [CNT_W-1:0] pix_q, line_q, width_q, height_q;
  logic [31:0] fc_q, period_q, timer_q, stall_q;
  logic ew_q, eh_q, es_q, eo_q;
  logic framed, beat, sof, cnt, stall;
  logic [CNT_W-1:0] pix_b, line_b, pix_inc, line_inc, pix_d, line_d;
  logic set_w, set_h, set_s, set_o;

  assign s_axis_video_tready = m_axis_video_tready;
  assign m_axis_video_tvalid = s_axis_video_tvalid;
  assign m_axis_video_tuser  = s_axis_video_tuser;
  assign m_axis_video_tlast  = s_axis_video_tlast;

  for (genvar k = 0; k < NUM_COMP; k++) begin : g_comp
    logic [IN_COMP_W-1:0] c;
    logic unused_c;
    assign c = s_axis_video_tdata[k*IN_COMP_W +: IN_COMP_W];
    assign unused_c = ^c;
    if (IN_COMP_W == OUT_COMP_W || ROUND == 0) begin : g_trunc
      assign m_axis_video_tdata[k*OUT_COMP_W +: OUT_COMP_W] = c[IN_COMP_W-1 -: OUT_COMP_W];
    end else begin : g_round
      logic [OUT_COMP_W:0] s;
      assign s = {1'b0, c[IN_COMP_W-1 -: OUT_COMP_W]} + {{OUT_COMP_W{1'b0}}, c[IN_COMP_W-OUT_COMP_W-1]};
      assign m_axis_video_tdata[k*OUT_COMP_W +: OUT_COMP_W] = s[OUT_COMP_W] ? '1 : s[OUT_COMP_W-1:0];
    end
  end

  assign framed = state_q == IN_FRAME;
  assign beat   = s_axis_video_tvalid & m_axis_video_tready;
  assign sof    = beat & s_axis_video_tuser;
  assign cnt    = beat & (s_axis_video_tuser | framed);
  assign stall  = s_axis_video_tvalid & ~m_axis_video_tready;
  // An SOF beat restarts the line first, so a tuser+tlast beat closes a 1-pixel line.
  assign pix_b    = s_axis_video_tuser ? '0 : pix_q;
  assign line_b   = s_axis_video_tuser ? '0 : line_q;
  assign pix_inc  = &pix_b ? pix_b : pix_b + CNT_W'(1);
  assign line_inc = &line_b ? line_b : line_b + CNT_W'(1);
  assign pix_d    = !cnt ? pix_q : (s_axis_video_tlast ? '0 : pix_inc);
  assign line_d   = !cnt ? line_q : (s_axis_video_tlast ? line_inc : line_b);
  assign set_w = cnt & s_axis_video_tlast & (pix_inc != CNT_W'(EXP_WIDTH));
  assign set_h = sof & framed & (line_q != CNT_W'(EXP_HEIGHT));
  assign set_s = sof & framed & (pix_q != '0);
  assign set_o = beat & ~s_axis_video_tuser & ~framed;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= WAIT_SOF;
      have_sof_q <= 1'b0;
      pix_q      <= '0;
      line_q     <= '0;
      width_q    <= '0;
      height_q   <= '0;
      fc_q       <= '0;
      period_q   <= '0;
      timer_q    <= '0;
      stall_q    <= '0;
      ew_q       <= 1'b0;
      eh_q       <= 1'b0;
      es_q       <= 1'b0;
      eo_q       <= 1'b0;
    end else begin
      state_q    <= sof ? IN_FRAME : (clr ? WAIT_SOF : state_q);
      have_sof_q <= sof | (have_sof_q & ~clr);
      pix_q      <= (clr & ~sof) ? '0 : pix_d;
      line_q     <= (clr & ~sof) ? '0 : line_d;
      width_q    <= clr ? '0 : ((cnt & s_axis_video_tlast) ? pix_inc : width_q);
      height_q   <= clr ? '0 : ((sof & framed) ? line_q : height_q);
      fc_q       <= clr ? 32'(sof) : fc_q + 32'(sof);
      period_q   <= clr ? '0 : ((sof & have_sof_q) ? timer_q : period_q);
      timer_q    <= sof ? 32'd1 : (clr ? '0 : (&timer_q ? timer_q : timer_q + 32'd1));
      stall_q    <= clr ? '0 : ((stall & ~&stall_q) ? stall_q + 32'd1 : stall_q);
      ew_q       <= set_w | (ew_q & ~clr);
      eh_q       <= set_h | (eh_q & ~clr);
      es_q       <= set_s | (es_q & ~clr);
      eo_q       <= set_o | (eo_q & ~clr);
    end
  end

  assign in_frame     = framed;
  assign frame_count  = fc_q;
  assign last_width   = width_q;
  assign last_height  = height_q;
  assign frame_period = period_q;
  assign stall_count  = stall_q;
  assign err_width    = ew_q;
  assign err_height   = eh_q;
  assign err_sof      = es_q;
  assign err_orphan   = eo_q;
endmodule

// File: doc/video_stream_monitor.md
# video_stream_monitor

Parametrised AXI4-Stream video pass-through with an in-line frame-geometry monitor, sitting between the camera/gamma path and the video DMA/VDMA. The data path forwards the stream with zero latency and reduces each colour component from IN_COMP_W to OUT_COMP_W bits, by truncation or rounding. The monitor counts handshaken beats rather than raw valid cycles, measures line width, frame height and frame period, and raises sticky errors when the geometry differs from the expected values. Status ports go to an AXI-Lite register bank or an ILA.

## Interface
- NUM_COMP, 3, number of colour components per pixel
- IN_COMP_W, 10, input bits per component; must be ≥ OUT_COMP_W
- OUT_COMP_W, 8, output bits per component
- ROUND, 0, 0 = truncate to the MSBs; 1 = round-half-up with saturation
- EXP_WIDTH, 1280, expected pixels per line
- EXP_HEIGHT, 720, expected lines per frame
- CNT_W, 16, width of the pixel and line counters
- clk  in  1  single clock; all logic is on its rising edge
- rstn  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of counters and sticky errors
- s_axis_video_tdata  in  NUM_COMP*IN_COMP_W  input pixel; component k is at [k*IN_COMP_W +: IN_COMP_W]
- s_axis_video_tvalid/tuser/tlast  in  1 each  input stream
- s_axis_video_tready  out  1  equal to m_axis_video_tready
- m_axis_video_tdata  out  NUM_COMP*OUT_COMP_W  reduced pixel, components in the same order
- m_axis_video_tvalid/tuser/tlast  out  1 each  equal to the s_ inputs
- m_axis_video_tready  in  1  downstream ready
- in_frame  out  1  state is IN_FRAME
- frame_count  out  32  SOF beats accepted
- last_width  out  CNT_W  pixel count of the most recent completed line
- last_height  out  CNT_W  line count of the most recent completed frame
- frame_period  out  32  clk cycles between the last two SOF beats
- stall_count  out  32  cycles with tvalid=1 and tready=0
- err_width, err_height, err_sof, err_orphan  out  1 each  sticky error flags

## Operation
- A beat is tvalid & tready. Counters and state change only on beats, except stall_count and the period timer.
- Data path is purely combinational.
  - ROUND=0: out_k = in_k[IN-1 -: OUT].
  - ROUND=1: out_k = MSBs + in_k[IN-OUT-1], saturating at all-ones.
  - When IN_COMP_W equals OUT_COMP_W, data passes unchanged.
- FSM has two states, WAIT_SOF and IN_FRAME. Reset state is WAIT_SOF.
- WAIT_SOF:
  - A beat with tuser=0 sets err_orphan and is not counted.
  - A tuser beat moves the FSM to IN_FRAME and starts the first frame.
- pix_cnt counts beats in the current line and saturates at all-ones.
- tlast beat:
  - last_width is loaded with pix_cnt+1, saturating.
  - err_width is set if that value ≠ EXP_WIDTH.
  - line_cnt increments, saturating.
  - pix_cnt returns to 0.
- tuser beat while IN_FRAME:
  - The previous frame is closed: last_height is loaded with line_cnt, and err_height is set if line_cnt ≠ EXP_HEIGHT.
  - err_sof is set if pix_cnt ≠ 0, i.e. SOF arrived mid-line.
  - pix_cnt and line_cnt restart, with the current beat counted as pixel 0.
- Every tuser beat, in either state:
  - frame_count increments, wrapping.
  - frame_period is loaded with the period timer, except on the first SOF after reset or clr.
  - The period timer restarts at 1.
- The period timer increments every cycle and saturates at 2^32-1.
- A beat with both tuser and tlast is a complete 1-pixel line: SOF handling runs first, then EOL handling with pix_cnt=0, so last_width=1.
- clr:
  - Zeroes all counters and status outputs, clears the errors and returns the FSM to WAIT_SOF.
  - An error condition on the same cycle as clr still sets its flag, so no event is lost.
  - A tuser beat on the same cycle as clr is honoured: FSM goes to IN_FRAME and frame_count=1.

## Timing
- Data path latency is 0 cycles. tready, tvalid, tuser and tlast are pure wires.
- Status outputs and error flags update on the clock edge that accepts the causing beat and are visible the next cycle.
- stall_count updates one cycle after the stall cycle and saturates at 2^32-1.
- Reset values: every status output, counter and error flag is 0; FSM is WAIT_SOF; in_frame=0.
- Reset asserted mid-frame aborts the measurement. After release, beats before the next SOF set err_orphan.

## Test plan
- Test 1, nominal frames: EXP 8x4, three frames of 8x4 with random tvalid/tready gaps.
  - frame_count=3, last_width=8, last_height=4, no errors.
  - stall_count equals the number of tvalid&!tready cycles.
- Test 2, short line: second line has 7 pixels.
  - err_width=1 and last_width=7 one cycle after that tlast beat.
  - err_height stays 0.
- Test 3, mid-line SOF and height: tuser arrives at pixel 3 of line 2, then the stream continues.
  - err_sof=1, last_height=2, err_height=1.
- Test 4, orphan beats: 5 beats without tuser after reset.
  - err_orphan=1, frame_count=0, in_frame=0.
  - The following SOF gives in_frame=1.
- Test 5, data path with ROUND=1, IN=10, OUT=8:
  - input 10'h3FF → 8'hFF (saturated).
  - 10'h002 → 8'h01.
  - 10'h001 → 8'h00.
  - ROUND=0 with 10'h3FE → 8'hFF.
- Test 6, clr and 1-pixel lines:
  - clr on the same cycle as a width error leaves err_width=1 and all counters 0.
  - A tuser+tlast beat gives last_width=1.
  - frame_period equals the SOF spacing in cycles, e.g. 40.
